conv3x3_frame_ctrl: RTL and testbench
=====================================

# conv3x3_frame_ctrl

Frame-level controller for the 3x3 convolution engine. It holds the nine kernel weights, feeds one IMG_W x IMG_H raster frame of 8-bit pixels into the engine, and counts the engine's results. Only results whose 3x3 window lies fully inside the image are forwarded. It reports frame completion, or an error if the engine stalls. It sits between the pixel source and the downstream feature-map writer.

## Interface
- IMG_W, 480, pixels per row (≥3)
- IMG_H, 272, rows per frame (≥3)
- DRAIN_TO, 1024, idle cycles tolerated in DRAIN before error
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse; honoured only in IDLE
- cfg_we  in  1  weight write strobe; honoured only in IDLE
- cfg_addr  in  4  weight index: 0..8 = w11,w12,w13,w21,...,w33; 9..15 ignored
- cfg_wdata  in  8  signed weight value
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid&&s_ready
- s_data  in  8  signed pixel
- conv_valid_in  out  1  engine input strobe
- conv_din  out  8  engine pixel
- conv_weights  out  72  packed weights: [7:0]=w11 … [71:64]=w33
- conv_valid_out  in  1  engine result strobe
- conv_dout  in  18  signed engine result
- m_valid  out  1  forwarded result strobe; no backpressure
- m_data  out  18  forwarded result
- m_last  out  1  set with the final forwarded result of the frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful frame end
- err  out  1  sticky drain timeout; cleared by the next accepted start

## Operation
- The engine produces exactly one conv_valid_out per conv_valid_in, in raster order, at a fixed latency.
- Reset: all outputs 0, all weights 0, state IDLE, all counters 0.
- States and transitions:
  - IDLE → RUN on start. Clears err, in_cnt, out_col and out_row.
  - RUN: s_ready=1 while in_cnt < IMG_W*IMG_H. Each handshake increments in_cnt. When the last pixel is accepted, go to DRAIN.
  - DRAIN: s_ready=0. Wait for the remaining results. The watchdog counts cycles with no conv_valid_out and resets on each strobe.
  - DRAIN → DONE when the result at out_row=IMG_H-1, out_col=IMG_W-1 is received.
  - DRAIN → IDLE with err=1 when the watchdog reaches DRAIN_TO. done stays 0.
  - DONE: done=1 for one cycle, then IDLE.
- Result counting:
  - conv_valid_out is counted in RUN and DRAIN and ignored in IDLE and DONE.
  - out_col wraps at IMG_W-1 to 0 and increments out_row.
- Forwarding: a result is forwarded when out_col≥2 and out_row≥2. That gives (IMG_W-2)*(IMG_H-2) results per frame.
- m_last = forwarded result at out_col=IMG_W-1, out_row=IMG_H-1.
- Weights:
  - cfg_we in IDLE writes weight[cfg_addr] at the clock edge.
  - Writes outside IDLE are ignored, so conv_weights stays constant for the whole frame.
- Boundary cases:
  - start and cfg_we in the same IDLE cycle: both take effect, and the frame uses the new weight.
  - start outside IDLE: ignored.
  - rst_n asserted mid-frame: immediate return to reset values, with no done pulse.

## Timing
- conv_valid_in and conv_din are registered from s_valid&&s_ready and s_data: 1-cycle latency.
- m_valid, m_data and m_last are registered from conv_valid_out and conv_dout: 1-cycle latency.
- done is asserted the cycle after m_last.
- busy goes high the cycle after start is sampled.
- s_ready is a combinational function of state and in_cnt.

## Configuration
- CONV_CTRL_RELU_EN defined: m_data = (conv_dout < 0) ? 0 : conv_dout.
- CONV_CTRL_RELU_EN undefined: m_data = conv_dout unmodified. Counting and timing are identical in both builds.

## Test plan
Bench uses IMG_W=6, IMG_H=5, DRAIN_TO=16 and an engine model with 3-cycle latency.
1. Weight load: cfg writes to addr 0..8 with values 1..9 → conv_weights = 72'h090807060504030201. A write to addr 12 changes nothing.
2. Full frame, s_valid held high: s_ready high for exactly 30 cycles; 30 conv_valid_in pulses; 12 m_valid pulses; m_last on the 12th; done the cycle after; err=0.
3. Pixel gaps: s_valid toggling 1/0 → still 30 accepted pixels and 12 forwarded results. A second start mid-frame is ignored and busy stays 1.
4. Weights locked: cfg_we addr 4, data 8'h7F during RUN → conv_weights[39:32] unchanged.
5. Engine stall: the model stops after 20 results → err=1 16 cycles after the last strobe; state IDLE; no done. The next start clears err.
6. ReLU: conv_dout=-5 at a kept position → m_data=0 with CONV_CTRL_RELU_EN, 18'h3FFFB without.

Source files
------------

// File: rtl/conv3x3_frame_ctrl.sv
// Frame controller for the 3x3 convolution engine: weights, pixel feed, result gating.
// Define CONV_CTRL_RELU_EN to clamp negative forwarded results to zero.
module conv3x3_frame_ctrl #(
  parameter int IMG_W    = 480,
  parameter int IMG_H    = 272,
  parameter int DRAIN_TO = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        conv_valid_in,
  output logic [7:0]  conv_din,
  output logic [71:0] conv_weights,
  input  logic        conv_valid_out,
  input  logic [17:0] conv_dout,
  output logic        m_valid,
  output logic [17:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int XW   = $clog2(IMG_W + 1);
  localparam int YW   = $clog2(IMG_H + 1);
  localparam int TW   = $clog2(DRAIN_TO + 1);

  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
  localparam logic [CW-1:0] LAST_C = CW'(NPIX - 1);
  localparam logic [XW-1:0] XEND_C = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YEND_C = YW'(IMG_H - 1);
  localparam logic [TW-1:0] WEND_C = TW'(DRAIN_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      in_cnt_q;
  logic [XW-1:0]      col_q;
  logic [YW-1:0]      row_q;
  logic [TW-1:0]      wd_q;
  logic [8:0][7:0]    w_q;
  logic               cvi_q;
  logic [7:0]         din_q;
  logic               mv_q;
  logic [17:0]        md_q;
  logic               ml_q;
  logic               done_q;
  logic               err_q;

  logic               rdy;
  logic               hs;
  logic               cnt_en;
  logic               col_end;
  logic               at_end;
  logic               keep;
  logic               wd_exp;
  logic [17:0]        dout_f;

  always_comb begin
    rdy     = (state_q == RUN) && (in_cnt_q < NPIX_C);
    hs      = s_valid && rdy;
    cnt_en  = conv_valid_out &&
              ((state_q == RUN) || (state_q == DRAIN));
    col_end = (col_q == XEND_C);
    at_end  = col_end && (row_q == YEND_C);
    keep    = (col_q >= XW'(2)) && (row_q >= YW'(2));
    wd_exp  = !conv_valid_out && (wd_q == WEND_C);
  end

`ifdef CONV_CTRL_RELU_EN
  assign dout_f = conv_dout[17] ? 18'h0 : conv_dout;
`else
  assign dout_f = conv_dout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      wd_q     <= '0;
      w_q      <= '0;
      cvi_q    <= 1'b0;
      din_q    <= '0;
      mv_q     <= 1'b0;
      md_q     <= '0;
      ml_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cvi_q  <= hs;
      mv_q   <= 1'b0;
      ml_q   <= 1'b0;
      done_q <= 1'b0;
      if (hs) begin
        din_q <= s_data;
      end
      // raster position of the incoming result selects interior windows
      if (cnt_en) begin
        if (keep) begin
          mv_q <= 1'b1;
          md_q <= dout_f;
          ml_q <= at_end;
        end
        if (col_end) begin
          col_q <= '0;
          row_q <= row_q + YW'(1);
        end else begin
          col_q <= col_q + XW'(1);
        end
      end
      unique case (state_q)
        IDLE: begin
          if (cfg_we && (cfg_addr < 4'd9)) begin
            w_q[cfg_addr] <= cfg_wdata;
          end
          if (start) begin
            state_q  <= RUN;
            err_q    <= 1'b0;
            in_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            in_cnt_q <= in_cnt_q + CW'(1);
            if (in_cnt_q == LAST_C) begin
              state_q <= DRAIN;
              wd_q    <= '0;
            end
          end
        end
        DRAIN: begin
          if (cnt_en && at_end) begin
            state_q <= DONE;
          end else if (conv_valid_out) begin
            wd_q <= '0;
          end else if (wd_exp) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + TW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready       = rdy;
  assign conv_valid_in = cvi_q;
  assign conv_din      = din_q;
  assign conv_weights  = w_q;
  assign m_valid       = mv_q;
  assign m_data        = md_q;
  assign m_last        = ml_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_conv3x3_frame_ctrl.sv
// Randomized bench for conv3x3_frame_ctrl with a 3-cycle engine stand-in
// and a frame-level reference model compared every cycle.
module tb_conv3x3_frame_ctrl;

  localparam int W    = 6;
  localparam int H    = 5;
  localparam int TO   = 16;
  localparam int NPIX = W * H;

`ifdef CONV_CTRL_RELU_EN
  localparam logic [17:0] NEG5_EXP = 18'h0;
`else
  localparam logic [17:0] NEG5_EXP = 18'h3FFFB;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        conv_valid_in;
  logic [7:0]  conv_din;
  logic [71:0] conv_weights;
  logic        conv_valid_out;
  logic [17:0] conv_dout;
  logic        m_valid;
  logic [17:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  conv3x3_frame_ctrl #(
    .IMG_W(W),
    .IMG_H(H),
    .DRAIN_TO(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .conv_valid_in(conv_valid_in),
    .conv_din(conv_din),
    .conv_weights(conv_weights),
    .conv_valid_out(conv_valid_out),
    .conv_dout(conv_dout),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // engine stand-in: three register stages, result index 14 forced to -5
  logic [1:0] ev;
  int         eng_cnt;
  int         eng_limit = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev             <= '0;
      eng_cnt        <= 0;
      conv_valid_out <= 1'b0;
      conv_dout      <= '0;
    end else begin
      ev[0]          <= conv_valid_in;
      ev[1]          <= ev[0];
      conv_valid_out <= 1'b0;
      if (start && !busy) begin
        eng_cnt <= 0;
      end else if (ev[1] && (eng_limit == 0 || eng_cnt < eng_limit)) begin
        conv_valid_out <= 1'b1;
        conv_dout      <= (eng_cnt == 14) ? 18'h3FFFB : 18'($urandom);
        eng_cnt        <= eng_cnt + 1;
      end
    end
  end

  function automatic logic [17:0] relu(input logic [17:0] d);
`ifdef CONV_CTRL_RELU_EN
    return d[17] ? 18'h0 : d;
`else
    return d;
`endif
  endfunction

  // reference model: frame counts and raster index arithmetic
  bit          m_act, m_drain, m_fin;
  int          m_acc, m_res, m_idle;
  logic [71:0] x_w = '0;
  logic        x_cvi = 1'b0;
  logic [7:0]  x_din = '0;
  logic        x_mv = 1'b0;
  logic [17:0] x_md = '0;
  logic        x_ml = 1'b0;
  logic        x_done = 1'b0;
  logic        x_err = 1'b0;

  function automatic bit x_rdy();
    return m_act && !m_drain && !m_fin && (m_acc < NPIX);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 0; m_drain = 0; m_fin = 0;
        m_acc = 0; m_res = 0; m_idle = 0;
        x_w = '0; x_cvi = 0; x_din = '0; x_mv = 0;
        x_md = '0; x_ml = 0; x_done = 0; x_err = 0;
      end else begin
        bit hs;
        hs = s_valid && x_rdy();
        x_cvi = hs;
        if (hs) x_din = s_data;
        x_mv = 0; x_ml = 0; x_done = 0;
        if (!m_act) begin
          if (cfg_we && cfg_addr < 9) x_w[cfg_addr*8 +: 8] = cfg_wdata;
          if (start) begin
            m_act = 1; m_drain = 0; m_fin = 0;
            m_acc = 0; m_res = 0; x_err = 0;
          end
        end else if (m_fin) begin
          m_act = 0; m_fin = 0; x_done = 1;
        end else begin
          if (conv_valid_out) begin
            if (m_res % W >= 2 && m_res / W >= 2) begin
              x_mv = 1;
              x_md = relu(conv_dout);
              x_ml = (m_res == NPIX - 1);
            end
            m_res++;
          end
          if (m_drain) begin
            if (conv_valid_out && m_res == NPIX) m_fin = 1;
            else if (conv_valid_out) m_idle = 0;
            else begin
              m_idle++;
              if (m_idle == TO) begin m_act = 0; x_err = 1; end
            end
          end else if (hs) begin
            m_acc++;
            if (m_acc == NPIX) begin m_drain = 1; m_idle = 0; end
          end
        end
      end
    end
  end

  // per-cycle compare plus cumulative event counters
  int cyc = 0, n_rdy = 0, n_cvi = 0, n_mv = 0, n_done = 0;
  int ml_idx = 0, ml_cyc = -10, done_cyc = -20;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("s_ready", s_ready, x_rdy());
      chk("conv_valid_in", conv_valid_in, x_cvi);
      if (x_cvi) chk("conv_din", conv_din, x_din);
      chk("conv_weights", conv_weights, x_w);
      chk("m_valid", m_valid, x_mv);
      if (x_mv) chk("m_data", m_data, x_md);
      chk("m_last", m_last, x_ml);
      chk("busy", busy, m_act);
      chk("done", done, x_done);
      chk("err", err, x_err);
      if (s_ready) n_rdy++;
      if (conv_valid_in) n_cvi++;
      if (m_valid) n_mv++;
      if (m_last) begin ml_idx = n_mv; ml_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  // mode 0: s_valid held, 1: toggling with stray start, 2: random
  task automatic run_frame(input int mode, input bit started,
                           output logic [17:0] first_md);
    int  n;
    bit  got;
    got = 0;
    first_md = '0;
    if (!started) begin
      start = 1; s_valid = 0;
      tick();
      cfg_we = 0;
      start = 0;
    end
    n = 0;
    while (busy && n < 300) begin
      case (mode)
        0: s_valid = 1;
        1: s_valid = (n % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = 8'($urandom);
      cfg_we = (mode == 0 && n == 5);
      cfg_addr = 4'd4;
      cfg_wdata = 8'h7F;
      start = (mode == 1 && n == 9);
      tick();
      n++;
      if (m_valid && !got) begin got = 1; first_md = m_data; end
      if (mode == 1 && n == 10) chk("busy_after_stray_start", busy, 1);
    end
    s_valid = 0; cfg_we = 0; start = 0;
    chk("frame_bounded", n < 300, 1);
    tick();
    tick();
  endtask

  initial begin
    int r0, c0, m0, d0, nd0;
    logic [17:0] fmd;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_conv_valid_in", conv_valid_in, 0);
    chk("rst_conv_din", conv_din, 0);
    chk("rst_weights", conv_weights, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'(i + 1));
    cfg_write(4'd12, 8'hAA);
    tick();
    chk("weights_loaded", conv_weights, 72'h090807060504030201);

    r0 = n_rdy; c0 = n_cvi; m0 = n_mv; nd0 = n_done;
    run_frame(0, 0, fmd);
    chk("f0_ready_cycles", n_rdy - r0, NPIX);
    chk("f0_conv_in", n_cvi - c0, NPIX);
    chk("f0_forwarded", n_mv - m0, 12);
    chk("f0_last_is_12th", ml_idx - m0, 12);
    chk("f0_done_after_last", done_cyc - ml_cyc, 1);
    chk("f0_done_count", n_done - nd0, 1);
    chk("f0_err", err, 0);
    chk("f0_neg5_result", fmd, NEG5_EXP);
    chk("w22_locked", conv_weights[39:32], 8'h05);

    c0 = n_cvi; m0 = n_mv; nd0 = n_done;
    run_frame(1, 0, fmd);
    chk("f1_conv_in", n_cvi - c0, NPIX);
    chk("f1_forwarded", n_mv - m0, 12);
    chk("f1_done_count", n_done - nd0, 1);

    eng_limit = 20;
    d0 = n_done; m0 = n_mv;
    run_frame(0, 0, fmd);
    chk("stall_err", err, 1);
    chk("stall_idle", busy, 0);
    chk("stall_no_done", n_done - d0, 0);
    chk("stall_forwarded", n_mv - m0, 4);
    eng_limit = 0;
    start = 1;
    tick();
    start = 0;
    chk("err_cleared", err, 0);
    chk("busy_after_start", busy, 1);
    c0 = n_cvi;
    run_frame(2, 1, fmd);
    chk("f3_conv_in", n_cvi - c0, NPIX);
    chk("f3_err", err, 0);

    start = 1;
    s_valid = 1;
    tick();
    start = 0;
    repeat (10) tick();
    d0 = n_done;
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_weights", conv_weights, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_conv_valid_in", conv_valid_in, 0);
    s_valid = 0;
    tick();
    rst_n = 1;
    repeat (12) tick();
    chk("midrst_no_done", n_done - d0, 0);

    for (int i = 1; i < 9; i++) cfg_write(4'(i), 8'($urandom));
    cfg_we = 1; cfg_addr = 4'd0; cfg_wdata = 8'h11;
    m0 = n_mv; nd0 = n_done;
    run_frame(2, 0, fmd);
    chk("start_with_cfg_w11", conv_weights[7:0], 8'h11);
    chk("f4_forwarded", n_mv - m0, 12);
    chk("f4_done_count", n_done - nd0, 1);
    chk("f4_neg5_result", fmd, NEG5_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

endmodule
